cheat_loader: RTL and testbench

Cheat-code loader feeding the cheat engine's 129-bit `code` input. It assembles 16-byte cheat records from the HPS ioctl download stream into `{flags, addr, compare, replace}` words, converting each field from little-endian file order to numeric big-endian bus order. It then presents each record to the engine with a timed posedge strobe on bit 128. It sits between the ioctl download mux and the engine; on each new cheat download it also clears the engine.

---
 rtl/cheat_pkg.sv | 31 +++
 rtl/cheat_loader.sv | 135 +++++++++++++
 tb/tb_cheat_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cheat_pkg.sv
// Shared constants and state encoding for the cheat-code loader.
// Defines the layout of the 129-bit engine code word.
package cheat_pkg;

    localparam int CODE_STB_BIT = 128;
    localparam int FLAGS_LSB    = 96;
    localparam int ADDR_LSB     = 64;
    localparam int CMP_LSB      = 32;
    localparam int REPL_LSB     = 0;
    localparam int CODE_BYTES   = 16;

    typedef enum logic [1:0] {
        CL_IDLE,
        CL_STB_HI,
        CL_STB_LO
    } cl_state_t;

    // Bit offset in code[127:0] of the 16-bit download word k (0..7).
    // Field k>>1 counts flags, addr, compare, replace; the odd word is the upper half.
    function automatic int word_lsb(input int k);
        int field_lsb;
        case (k / 2)
            0:       field_lsb = FLAGS_LSB;
            1:       field_lsb = ADDR_LSB;
            2:       field_lsb = CMP_LSB;
            default: field_lsb = REPL_LSB;
        endcase
        return field_lsb + 16 * (k % 2);
    endfunction

endpackage

// File: rtl/cheat_loader.sv
// Assembles 16-byte cheat records from the ioctl download stream and presents
// each one to the cheat engine with a timed strobe on code[128].
module cheat_loader
    import cheat_pkg::*;
#(
    parameter int MAX_CODES     = 32,
    parameter int STROBE_CYCLES = 2,
    parameter int CNT_W         = $clog2(MAX_CODES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ioctl_download,
    input  logic             ioctl_wr,
    input  logic [24:0]      ioctl_addr,
    input  logic [15:0]      ioctl_dout,
    output logic             ioctl_wait,
    output logic             codes_reset,
    output logic [128:0]     code,
    output logic [CNT_W-1:0] loaded,
    output logic             overflow
);

    localparam int                SC_W      = $clog2(STROBE_CYCLES + 1);
    localparam logic [SC_W-1:0]   SC_RELOAD = SC_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CAPACITY  = CNT_W'(MAX_CODES);

    cl_state_t        state_reg;
    logic [SC_W-1:0]  stb_cnt_reg;
    logic             strobe_reg;
    logic [127:0]     code_reg;
    logic [127:0]     shadow_reg;
    logic [127:0]     shadow_base;
    logic [127:0]     shadow_next;
    logic [CNT_W-1:0] loaded_reg;
    logic [CNT_W-1:0] loaded_base;
    logic             overflow_reg;
    logic             codes_reset_reg;
    logic             dl_prev_reg;

    logic       dl_rise;
    logic       dl_fall;
    logic       accept;
    logic       complete;
    logic       has_room;
    logic [2:0] word_idx;
    logic       unused_addr;

    assign dl_rise  = ioctl_download & ~dl_prev_reg;
    assign dl_fall  = ~ioctl_download & dl_prev_reg;
    assign word_idx = ioctl_addr[3:1];
    // A download start aborts any strobe, so a write in that same cycle is taken.
    assign accept   = ioctl_download & ioctl_wr & ((state_reg == CL_IDLE) | dl_rise);
    assign complete = accept & (word_idx == 3'd7);

    assign shadow_base = (dl_rise | dl_fall) ? '0 : shadow_reg;
    assign loaded_base = dl_rise ? '0 : loaded_reg;
    assign has_room    = loaded_base < CAPACITY;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word
            localparam int LSB = word_lsb(gi);
            assign shadow_next[LSB +: 16] = (accept && word_idx == 3'(gi))
                                          ? ioctl_dout : shadow_base[LSB +: 16];
        end
    endgenerate

    assign unused_addr = ^{ioctl_addr[24:4], ioctl_addr[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= CL_IDLE;
            stb_cnt_reg     <= '0;
            strobe_reg      <= 1'b0;
            code_reg        <= '0;
            shadow_reg      <= '0;
            loaded_reg      <= '0;
            overflow_reg    <= 1'b0;
            codes_reset_reg <= 1'b0;
            dl_prev_reg     <= 1'b0;
        end else begin
            dl_prev_reg     <= ioctl_download;
            codes_reset_reg <= dl_rise;
            shadow_reg      <= shadow_next;
            loaded_reg      <= loaded_base;
            if (dl_rise) begin
                overflow_reg <= 1'b0;
            end
            if (state_reg == CL_IDLE || dl_rise) begin
                state_reg  <= CL_IDLE;
                strobe_reg <= 1'b0;
                if (complete) begin
                    if (has_room) begin
                        code_reg    <= shadow_next;
                        strobe_reg  <= 1'b1;
                        state_reg   <= CL_STB_HI;
                        stb_cnt_reg <= SC_RELOAD;
                        loaded_reg  <= loaded_base + 1'b1;
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                end
            end else begin
                case (state_reg)
                    CL_STB_HI: begin
                        if (stb_cnt_reg == '0) begin
                            state_reg   <= CL_STB_LO;
                            strobe_reg  <= 1'b0;
                            stb_cnt_reg <= SC_RELOAD;
                        end else begin
                            stb_cnt_reg <= stb_cnt_reg - 1'b1;
                        end
                    end
                    CL_STB_LO: begin
                        if (stb_cnt_reg == '0) begin
                            state_reg <= CL_IDLE;
                        end else begin
                            stb_cnt_reg <= stb_cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_reg  <= CL_IDLE;
                        strobe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ioctl_wait  = (state_reg != CL_IDLE);
    assign codes_reset = codes_reset_reg;
    assign code        = {strobe_reg, code_reg};
    assign loaded      = loaded_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_cheat_loader.sv
// Directed bench for cheat_loader: a default-capacity instance and a
// two-record instance share the same ioctl stimulus.
module tb_cheat_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         ioctl_download;
    logic         ioctl_wr;
    logic [24:0]  ioctl_addr;
    logic [15:0]  ioctl_dout;

    logic         wait_b, cr_b, ovf_b;
    logic [128:0] code_b;
    logic [5:0]   loaded_b;
    logic         wait_s, cr_s, ovf_s;
    logic [128:0] code_s;
    logic [1:0]   loaded_s;

    int vectors    = 0;
    int miscompares = 0;
    int cr_count   = 0;

    logic [15:0]  words [8];
    logic [127:0] exp_rec;

    always #5 clk = ~clk;

    cheat_loader dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(wait_b), .codes_reset(cr_b), .code(code_b),
        .loaded(loaded_b), .overflow(ovf_b)
    );

    cheat_loader #(.MAX_CODES(2)) dut_small (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(wait_s), .codes_reset(cr_s), .code(code_s),
        .loaded(loaded_s), .overflow(ovf_s)
    );

    always @(posedge clk) if (cr_b) cr_count <= cr_count + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build the 8 download words from the little-endian file bytes of a record.
    task automatic build(input logic [31:0] f, a, c, r);
        logic [7:0] b [16];
        logic [31:0] fld [4];
        fld[0] = f; fld[1] = a; fld[2] = c; fld[3] = r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) b[4*i+j] = fld[i][8*j +: 8];
        for (int w = 0; w < 8; w++) words[w] = {b[2*w+1], b[2*w]};
        exp_rec = {f, a, c, r};
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((wait_b || wait_s) && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (wait_b || wait_s) begin
            $display("FAIL wait_timeout: ioctl_wait still %b/%b, want 0", wait_b, wait_s);
            miscompares++;
        end
    endtask

    task automatic wr_word(input int rec, input int k, input logic [15:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(rec * 16 + k * 2);
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_record(input int rec);
        for (int k = 0; k < 8; k++) begin
            wait_ready();
            wr_word(rec, k, words[k]);
        end
        $display("record %0d sent: expect %h", rec, exp_rec);
    endtask

    task automatic start_download();
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({code_b, wait_b, cr_b, loaded_b, ovf_b} !== '0) begin
            $display("FAIL reset_state: got code=%h wait=%b cr=%b loaded=%0d ovf=%b, want all 0",
                     code_b, wait_b, cr_b, loaded_b, ovf_b);
            miscompares++;
        end
    endtask

    task automatic test_single();
        int cr_base;
        logic [1:0] exp_stb;
        build(32'h1, 32'h00123456, 32'hAB, 32'hCD);
        cr_base = cr_count;
        start_download();
        vectors++;
        if (cr_b !== 1'b1) begin
            $display("FAIL single_codes_reset: got %b want 1", cr_b); miscompares++;
        end
        tick();
        vectors++;
        if (cr_b !== 1'b0) begin
            $display("FAIL single_codes_reset_end: got %b want 0", cr_b); miscompares++;
        end
        send_record(0);
        vectors++;
        if (code_b[127:0] !== 128'h00000001_00123456_000000AB_000000CD || loaded_b !== 6'd1) begin
            $display("FAIL single_code: got %h loaded=%0d want %h loaded=1",
                     code_b[127:0], loaded_b, 128'h00000001_00123456_000000AB_000000CD);
            miscompares++;
        end
        for (int i = 0; i < 5; i++) begin
            exp_stb = {(i < 4) ? 1'b1 : 1'b0, (i < 2) ? 1'b1 : 1'b0};
            vectors++;
            if ({wait_b, code_b[128]} !== exp_stb || code_b[127:0] !== exp_rec) begin
                $display("FAIL single_seq[%0d]: got wait=%b stb=%b code=%h want wait=%b stb=%b code=%h",
                         i, wait_b, code_b[128], code_b[127:0], exp_stb[1], exp_stb[0], exp_rec);
                miscompares++;
            end
            tick();
        end
        vectors++;
        if (cr_count - cr_base !== 1) begin
            $display("FAIL single_cr_pulses: got %0d want 1", cr_count - cr_base); miscompares++;
        end
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3][4];
        int hi, lo, n;
        vals[0] = '{32'h11111111, 32'h00400000, 32'h00000022, 32'h00000033};
        vals[1] = '{32'h80000001, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0};
        vals[2] = '{32'h00000002, 32'h0000BEEF, 32'hA5A5A5A5, 32'h5A5A5A5A};
        start_download();
        for (int r = 0; r < 3; r++) begin
            build(vals[r][0], vals[r][1], vals[r][2], vals[r][3]);
            send_record(r);
            vectors++;
            if (code_b !== {1'b1, exp_rec} || loaded_b !== 6'(r + 1)) begin
                $display("FAIL b2b_rec%0d: got %h loaded=%0d want %h loaded=%0d",
                         r, code_b, loaded_b, {1'b1, exp_rec}, r + 1);
                miscompares++;
            end
            hi = 0; lo = 0; n = 0;
            while (wait_b && n < 20) begin
                if (code_b[128]) hi++; else lo++;
                tick();
                n++;
            end
            vectors++;
            if (hi != 2 || lo != 2) begin
                $display("FAIL b2b_timing%0d: got hi=%0d lo=%0d want hi=2 lo=2", r, hi, lo);
                miscompares++;
            end
        end
        build(32'h0000CAFE, 32'h1, 32'h2, 32'h3);
        send_record(3);
        wr_word(3, 7, 16'hFFFF);
        wait_ready();
        tick();
        vectors++;
        if (loaded_b !== 6'd4 || code_b !== {1'b0, exp_rec}) begin
            $display("FAIL b2b_forced_write: got %h loaded=%0d want %h loaded=4",
                     code_b, loaded_b, {1'b0, exp_rec});
            miscompares++;
        end
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [127:0] rec_b;
        start_download();
        build(32'hA, 32'hA0, 32'hA00, 32'hA000);
        send_record(0);
        vectors++;
        if (loaded_s !== 2'd1 || code_s !== {1'b1, exp_rec}) begin
            $display("FAIL ovf_rec0: got %h loaded=%0d want %h loaded=1", code_s, loaded_s, {1'b1, exp_rec});
            miscompares++;
        end
        build(32'hB, 32'hB0, 32'hB00, 32'hB000);
        rec_b = exp_rec;
        send_record(1);
        vectors++;
        if (loaded_s !== 2'd2 || code_s !== {1'b1, rec_b} || ovf_s !== 1'b0) begin
            $display("FAIL ovf_rec1: got %h loaded=%0d ovf=%b want %h loaded=2 ovf=0",
                     code_s, loaded_s, ovf_s, {1'b1, rec_b});
            miscompares++;
        end
        build(32'hC, 32'hC0, 32'hC00, 32'hC000);
        send_record(2);
        vectors++;
        if (ovf_s !== 1'b1 || wait_s !== 1'b0 || loaded_s !== 2'd2 || code_s !== {1'b0, rec_b}) begin
            $display("FAIL ovf_rec2: got ovf=%b wait=%b loaded=%0d code=%h want ovf=1 wait=0 loaded=2 code=%h",
                     ovf_s, wait_s, loaded_s, code_s, {1'b0, rec_b});
            miscompares++;
        end
        wait_ready();
    endtask

    task automatic test_restart();
        start_download();
        vectors++;
        if (cr_s !== 1'b1 || loaded_s !== 2'd0 || ovf_s !== 1'b0) begin
            $display("FAIL restart: got cr=%b loaded=%0d ovf=%b want cr=1 loaded=0 ovf=0",
                     cr_s, loaded_s, ovf_s);
            miscompares++;
        end
        tick();
        vectors++;
        if (cr_s !== 1'b0) begin
            $display("FAIL restart_cr_end: got %b want 0", cr_s); miscompares++;
        end
    endtask

    task automatic test_partial();
        build(32'hDEADBEEF, 32'hCAFEF00D, 32'h0000AAAA, 32'h0);
        for (int k = 0; k < 5; k++) wr_word(0, k, words[k]);
        ioctl_download = 1'b0;
        tick();
        wr_word(0, 7, 16'h1111);
        tick();
        vectors++;
        if (code_b[128] !== 1'b0 || loaded_b !== 6'd0) begin
            $display("FAIL write_outside_download: got stb=%b loaded=%0d want stb=0 loaded=0",
                     code_b[128], loaded_b);
            miscompares++;
        end
        ioctl_download = 1'b1;
        tick();
        build(32'h0, 32'h0, 32'hC0DE0000, 32'h87654321);
        for (int k = 5; k < 8; k++) wr_word(1, k, words[k]);
        $display("partial record sent: expect %h", exp_rec);
        vectors++;
        if (code_b !== {1'b1, 128'h00000000_00000000_C0DE0000_87654321} || loaded_b !== 6'd1) begin
            $display("FAIL partial_discard: got %h loaded=%0d want %h loaded=1",
                     code_b, loaded_b, {1'b1, 128'h00000000_00000000_C0DE0000_87654321});
            miscompares++;
        end
        wait_ready();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        start_download();
        build(32'h77, 32'h88, 32'h99, 32'hAA);
        send_record(0);
        tick();
        vectors++;
        if (code_b[128] !== 1'b1) begin
            $display("FAIL reset_mid_pre: got stb=%b want 1", code_b[128]); miscompares++;
        end
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        vectors++;
        if (code_b !== '0 || wait_b !== 1'b0 || loaded_b !== 6'd0) begin
            $display("FAIL reset_mid: got code=%h wait=%b loaded=%0d want code=0 wait=0 loaded=0",
                     code_b, wait_b, loaded_b);
            miscompares++;
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_partial();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
